// File: rtl/wb_stage_pipe.sv
// Write-back stage: selects ALU / load / link data, aligns and extends loads, and holds the
// result in a one-entry valid/ready register. Optional retire counter under WB_RETIRE_CNT_EN.
module wb_stage_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5
`ifdef WB_RETIRE_CNT_EN
   ,parameter int unsigned CNT_W = 64
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [XLEN-1:0]             alu_result,
    input  logic [XLEN-1:0]             mem_data,
    input  logic [XLEN-1:0]             pc_plus4,
    input  logic [1:0]                  wb_sel,
    input  logic [1:0]                  load_size,
    input  logic                        load_unsigned,
    input  logic [$clog2(XLEN/8)-1:0]   byte_off,
    input  logic [RA_W-1:0]             rd_addr,
    input  logic                        reg_write,
    input  logic                        rf_ready,
    output logic                        out_valid,
    output logic                        rf_we,
    output logic [RA_W-1:0]             rf_waddr,
    output logic [XLEN-1:0]             rf_wdata
`ifdef WB_RETIRE_CNT_EN
   ,output logic [CNT_W-1:0]            retire_cnt
`endif
);

    localparam int unsigned OFF_W = $clog2(XLEN/8);

    logic              r_valid;
    logic              r_reg_write;
    logic [RA_W-1:0]   r_rd;
    logic [XLEN-1:0]   r_data;

    logic              w_accept;
    logic              w_drain;
    logic [OFF_W-1:0]  w_sh;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_mask;
    logic              w_msb;
    logic              w_sext;
    logic [XLEN-1:0]   w_load;
    logic [XLEN-1:0]   w_wb_data;

    assign in_ready = !r_valid || rf_ready;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_drain  = r_valid && rf_ready && !flush;

    // Lane offset: low offset bits are dropped for halves and words.
    always_comb begin
        w_sh = byte_off;
        unique case (load_size)
            2'b00:   w_sh = byte_off;
            2'b01:   w_sh = (byte_off >> 1) << 1;
            2'b10:   w_sh = (byte_off >> 2) << 2;
            default: w_sh = '0;
        endcase
    end

    assign w_shifted = mem_data >> {w_sh, 3'b000};

    // Word mask is all ones when XLEN=32, so a word load then behaves as a full-width load.
    always_comb begin
        w_mask = '1;
        w_msb  = 1'b0;
        unique case (load_size)
            2'b00: begin
                w_mask = XLEN'(8'hFF);
                w_msb  = w_shifted[7];
            end
            2'b01: begin
                w_mask = XLEN'(16'hFFFF);
                w_msb  = w_shifted[15];
            end
            2'b10: begin
                w_mask = XLEN'(32'hFFFF_FFFF);
                w_msb  = w_shifted[31];
            end
            default: begin
                w_mask = '1;
                w_msb  = 1'b0;
            end
        endcase
    end

    assign w_sext = !load_unsigned && w_msb && (load_size != 2'b11);
    assign w_load = w_sext ? (w_shifted | ~w_mask) : (w_shifted & w_mask);

    always_comb begin
        w_wb_data = alu_result;
        unique case (wb_sel)
            2'b01:   w_wb_data = w_load;
            2'b10:   w_wb_data = pc_plus4;
            default: w_wb_data = alu_result;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_data      <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_reg_write <= reg_write;
            r_rd        <= rd_addr;
            r_data      <= w_wb_data;
        end else if (w_drain) begin
            r_valid     <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign rf_we     = r_valid && r_reg_write && (r_rd != '0);
    assign rf_waddr  = r_rd;
    assign rf_wdata  = r_data;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (w_drain) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe (XLEN=32): vector table plus back-pressure, flush,
// async reset and (with WB_RETIRE_CNT_EN) retire counter sequences.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result = '0;
    logic [31:0] mem_data = '0;
    logic [31:0] pc_plus4 = '0;
    logic [1:0]  wb_sel = '0;
    logic [1:0]  load_size = '0;
    logic        load_unsigned = 1'b0;
    logic [1:0]  byte_off = '0;
    logic [4:0]  rd_addr = '0;
    logic        reg_write = 1'b0;
    logic        rf_ready = 1'b1;
    logic        out_valid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
    logic [3:0]  retire_cnt4;
    logic        in_ready4, out_valid4, rf_we4;
    logic [4:0]  rf_waddr4;
    logic [31:0] rf_wdata4;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_stage_pipe #(
        .XLEN (32),
        .RA_W (5)
`ifdef WB_RETIRE_CNT_EN
       ,.CNT_W(64)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .mem_data      (mem_data),
        .pc_plus4      (pc_plus4),
        .wb_sel        (wb_sel),
        .load_size     (load_size),
        .load_unsigned (load_unsigned),
        .byte_off      (byte_off),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .rf_ready      (rf_ready),
        .out_valid     (out_valid),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
`ifdef WB_RETIRE_CNT_EN
       ,.retire_cnt    (retire_cnt)
`endif
    );

`ifdef WB_RETIRE_CNT_EN
    wb_stage_pipe #(
        .XLEN (32),
        .RA_W (5),
        .CNT_W(4)
    ) dut4 (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready4),
        .alu_result    (alu_result),
        .mem_data      (mem_data),
        .pc_plus4      (pc_plus4),
        .wb_sel        (wb_sel),
        .load_size     (load_size),
        .load_unsigned (load_unsigned),
        .byte_off      (byte_off),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .rf_ready      (rf_ready),
        .out_valid     (out_valid4),
        .rf_we         (rf_we4),
        .rf_waddr      (rf_waddr4),
        .rf_wdata      (rf_wdata4),
        .retire_cnt    (retire_cnt4)
    );
`endif

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        wb_sel        = v.sel;
        load_size     = v.size;
        load_unsigned = v.uns;
        byte_off      = v.off;
        alu_result    = v.alu;
        mem_data      = v.mem;
        pc_plus4      = v.pc;
        rd_addr       = v.rd;
        reg_write     = v.rw;
    endtask

    task automatic simple(input logic [31:0] alu, input logic [4:0] rd);
        wb_sel     = 2'b00;
        alu_result = alu;
        rd_addr    = rd;
        reg_write  = 1'b1;
    endtask

    initial begin
        //          sel    size   uns   off    alu           mem           pc            rd     rw    exp           we
        vecs[0]  = '{2'b00, 2'b00, 1'b0, 2'd0, 32'hAAAA_BBBB, 32'h0,        32'h0,        5'd5,  1'b1, 32'hAAAA_BBBB, 1'b1};
        vecs[1]  = '{2'b01, 2'b00, 1'b0, 2'd1, 32'h0,        32'hDEAD_BEEF, 32'h0,        5'd1,  1'b1, 32'hFFFF_FFBE, 1'b1};
        vecs[2]  = '{2'b01, 2'b00, 1'b1, 2'd1, 32'h0,        32'hDEAD_BEEF, 32'h0,        5'd2,  1'b1, 32'h0000_00BE, 1'b1};
        vecs[3]  = '{2'b01, 2'b01, 1'b0, 2'd2, 32'h0,        32'hDEAD_BEEF, 32'h0,        5'd3,  1'b1, 32'hFFFF_DEAD, 1'b1};
        vecs[4]  = '{2'b01, 2'b01, 1'b1, 2'd2, 32'h0,        32'hDEAD_BEEF, 32'h0,        5'd4,  1'b1, 32'h0000_DEAD, 1'b1};
        vecs[5]  = '{2'b01, 2'b01, 1'b0, 2'd3, 32'h0,        32'hDEAD_BEEF, 32'h0,        5'd6,  1'b1, 32'hFFFF_DEAD, 1'b1};
        vecs[6]  = '{2'b01, 2'b01, 1'b0, 2'd1, 32'h0,        32'h1234_5678, 32'h0,        5'd7,  1'b1, 32'h0000_5678, 1'b1};
        vecs[7]  = '{2'b01, 2'b00, 1'b0, 2'd3, 32'h0,        32'h7F00_0000, 32'h0,        5'd8,  1'b1, 32'h0000_007F, 1'b1};
        vecs[8]  = '{2'b01, 2'b10, 1'b0, 2'd3, 32'h0,        32'h8000_0001, 32'h0,        5'd9,  1'b1, 32'h8000_0001, 1'b1};
        vecs[9]  = '{2'b01, 2'b11, 1'b1, 2'd0, 32'h0,        32'h8000_0001, 32'h0,        5'd10, 1'b1, 32'h8000_0001, 1'b1};
        vecs[10] = '{2'b01, 2'b00, 1'b0, 2'd0, 32'h0,        32'hDEAD_BEEF, 32'h0,        5'd11, 1'b1, 32'hFFFF_FFEF, 1'b1};
        vecs[11] = '{2'b10, 2'b00, 1'b0, 2'd0, 32'h5555_5555, 32'h0,        32'h0000_1004, 5'd1,  1'b1, 32'h0000_1004, 1'b1};
        vecs[12] = '{2'b11, 2'b00, 1'b0, 2'd0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h9,        5'd12, 1'b1, 32'h1234_5678, 1'b1};
        vecs[13] = '{2'b00, 2'b00, 1'b0, 2'd0, 32'hCAFE_F00D, 32'h0,        32'h0,        5'd0,  1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[14] = '{2'b01, 2'b00, 1'b1, 2'd2, 32'h0,        32'hDEAD_BEEF, 32'h0,        5'd7,  1'b0, 32'h0000_00AD, 1'b0};

        // Reset state
        step();
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset rf_we", 64'(rf_we), 64'd0);
        check("reset rf_waddr", 64'(rf_waddr), 64'd0);
        check("reset rf_wdata", 64'(rf_wdata), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        step();

        // Vector table, back-to-back with rf_ready=1
        rf_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            step();
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d rf_we", i), 64'(rf_we), 64'(vecs[i].exp_we));
            check($sformatf("vec%0d rf_waddr", i), 64'(rf_waddr), 64'(vecs[i].rd));
            check($sformatf("vec%0d rf_wdata", i), 64'(rf_wdata), 64'(vecs[i].exp_data));
        end
        in_valid = 1'b0;
        step();
        check("drain out_valid", 64'(out_valid), 64'd0);

        // Back-pressure: A held for 3 stalled cycles, then A drains and B loads together
        rf_ready = 1'b0;
        in_valid = 1'b1;
        simple(32'hAAAA_0001, 5'd5);
        step();
        check("bp A loaded", 64'(rf_wdata), 64'hAAAA_0001);
        simple(32'hBBBB_0002, 5'd6);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp stall%0d in_ready", c), 64'(in_ready), 64'd0);
            step();
            check($sformatf("bp stall%0d out_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("bp stall%0d wdata", c), 64'(rf_wdata), 64'hAAAA_0001);
            check($sformatf("bp stall%0d waddr", c), 64'(rf_waddr), 64'd5);
        end
        rf_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(in_ready), 64'd1);
        step();
        check("bp B out_valid", 64'(out_valid), 64'd1);
        check("bp B wdata", 64'(rf_wdata), 64'hBBBB_0002);
        check("bp B waddr", 64'(rf_waddr), 64'd6);
        in_valid = 1'b0;
        step();
        check("bp empty", 64'(out_valid), 64'd0);

        // Flush with in_valid on an empty stage, then flush of a held entry
        flush = 1'b1;
        in_valid = 1'b1;
        simple(32'h0000_F00D, 5'd9);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush drop out_valid", 64'(out_valid), 64'd0);
        check("flush drop rf_we", 64'(rf_we), 64'd0);
        rf_ready = 1'b0;
        in_valid = 1'b1;
        simple(32'h0000_C0C0, 5'd10);
        step();
        in_valid = 1'b0;
        check("flush held loaded", 64'(out_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush held out_valid", 64'(out_valid), 64'd0);
        check("flush held rf_we", 64'(rf_we), 64'd0);

        // Asynchronous reset in the middle of a stall
        in_valid = 1'b1;
        simple(32'h1111_2222, 5'd3);
        step();
        in_valid = 1'b0;
        check("rst pre out_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst rf_we", 64'(rf_we), 64'd0);
        check("async rst rf_waddr", 64'(rf_waddr), 64'd0);
        check("async rst rf_wdata", 64'(rf_wdata), 64'd0);
        check("async rst in_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        rf_ready = 1'b1;
        step();

`ifdef WB_RETIRE_CNT_EN
        // 10 drain opportunities: one to x0, one flushed -> 9 retired
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("cnt reset", retire_cnt, 64'd0);
        rf_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            simple(32'(k), (k == 2) ? 5'd0 : 5'(k + 1));
            step();
        end
        simple(32'hDEAD, 5'd4);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            simple(32'(k), 5'd1);
            step();
        end
        in_valid = 1'b0;
        step();
        check("cnt after 9", retire_cnt, 64'd9);
        check("cnt4 after 9", 64'(retire_cnt4), 64'd9);
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            simple(32'(k), 5'd2);
            step();
        end
        in_valid = 1'b0;
        step();
        check("cnt after 17", retire_cnt, 64'd17);
        check("cnt4 wrap 17", 64'(retire_cnt4), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
